// File: rtl/host_link_pkg.sv
// Shared types and sizing helpers for the host-side mailbox link.
package host_link_pkg;

    typedef enum logic [0:0] {
        RX_COLLECT,
        RX_PUSH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_DONE,
        TX_WAIT
    } tx_state_t;

    function automatic int unsigned bpw(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Byte counters stay at least 1 bit wide so a one-byte word still builds.
    function automatic int unsigned cnt_w(input int unsigned data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/host_link_ser.sv
// Host TX serializer: holds the outgoing mailbox word and hands it out LSB byte first.
module host_link_ser
    import host_link_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [7:0]        host_tx_data,
    output logic              host_tx_vld,
    input  logic              host_tx_rdy,
    output logic              last_xfer
);

    localparam int unsigned BPW   = bpw(DATA_W);
    localparam int unsigned CNT_W = cnt_w(DATA_W);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  tx_cnt;
    logic              busy;
    logic              xfer;

    assign host_tx_vld  = busy;
    assign host_tx_data = shreg[7:0];
    assign xfer         = busy && host_tx_rdy;
    assign last_xfer    = xfer && (tx_cnt == CNT_W'(BPW - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            tx_cnt <= '0;
            busy   <= 1'b0;
        end else if (load) begin
            shreg  <= load_data;
            tx_cnt <= '0;
            busy   <= 1'b1;
        end else if (xfer) begin
            shreg <= shreg >> 8;
            if (last_xfer) begin
                tx_cnt <= '0;
                busy   <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/host_link.sv
// Host-side mailbox peer: packs host bytes into words for the core and serializes core words to the host.
// Optional partial-word RX timeout is enabled by defining HOST_LINK_TIMEOUT_EN.
module host_link
    import host_link_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        host_rx_data,
    input  logic              host_rx_vld,
    output logic              host_rx_rdy,
    output logic [7:0]        host_tx_data,
    output logic              host_tx_vld,
    input  logic              host_tx_rdy,
    output logic [DATA_W-1:0] mb_rd_data,
    output logic              mb_rd_push,
    input  logic              mb_rd_full,
    input  logic [DATA_W-1:0] mb_wr_data,
    input  logic              mb_wr_req,
    output logic              tx_done,
    output logic              ready,
    output logic              rx_err
);

    localparam int unsigned BPW   = bpw(DATA_W);
    localparam int unsigned CNT_W = cnt_w(DATA_W);

    rx_state_t         rx_state, rx_next;
    tx_state_t         tx_state, tx_next;
    logic [CNT_W-1:0]  rx_cnt;
    logic [DATA_W-1:0] rx_word;
    logic              rx_acc;
    logic              rx_last;
    logic              rx_drop;
    logic              ser_load;
    logic              ser_last;

    assign host_rx_rdy = (rx_state == RX_COLLECT);
    assign rx_acc      = host_rx_rdy && host_rx_vld;
    assign rx_last     = rx_acc && (rx_cnt == CNT_W'(BPW - 1));
    assign mb_rd_push  = (rx_state == RX_PUSH) && !mb_rd_full;
    assign mb_rd_data  = rx_word;
    assign tx_done     = (tx_state == TX_DONE);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_COLLECT: if (rx_last) rx_next = RX_PUSH;
            RX_PUSH:    if (!mb_rd_full) rx_next = RX_COLLECT;
            default:    rx_next = RX_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_COLLECT;
            rx_cnt   <= '0;
            rx_word  <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_acc) begin
                for (int unsigned i = 0; i < BPW; i++) begin
                    if (rx_cnt == CNT_W'(i)) rx_word[8*i +: 8] <= host_rx_data;
                end
                rx_cnt <= rx_last ? '0 : rx_cnt + 1'b1;
            end else if (rx_drop) begin
                rx_cnt <= '0;
            end
        end
    end

`ifdef HOST_LINK_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             rx_err_q;

    // An arriving byte takes priority over a timeout landing on the same cycle.
    assign rx_drop = (rx_state == RX_COLLECT) && !rx_acc && (rx_cnt != '0)
                     && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign rx_err  = rx_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt  <= '0;
            rx_err_q <= 1'b0;
        end else begin
            if (rx_acc || rx_drop || (rx_state != RX_COLLECT) || (rx_cnt == '0)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (rx_drop) rx_err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign rx_drop        = 1'b0;
    assign rx_err         = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_comb begin
        tx_next  = tx_state;
        ser_load = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (mb_wr_req) begin
                    ser_load = 1'b1;
                    tx_next  = TX_SEND;
                end
            end
            TX_SEND: if (ser_last) tx_next = TX_DONE;
            TX_DONE: tx_next = TX_WAIT;
            TX_WAIT: if (!mb_wr_req) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // ready is registered from the next states so it tracks the current states exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            ready    <= 1'b1;
        end else begin
            tx_state <= tx_next;
            ready    <= (rx_next == RX_COLLECT) && (tx_next == TX_IDLE);
        end
    end

    host_link_ser #(
        .DATA_W(DATA_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load        (ser_load),
        .load_data   (mb_wr_data),
        .host_tx_data(host_tx_data),
        .host_tx_vld (host_tx_vld),
        .host_tx_rdy (host_tx_rdy),
        .last_xfer   (ser_last)
    );

endmodule

// File: tb/tb_host_link.sv
// Directed bench for host_link with a transaction-level reference model checked every cycle.
module tb_host_link;

    localparam int unsigned DW  = 32;
    localparam int unsigned BPW = DW / 8;
    localparam int unsigned TMO = 16;

    logic          clk;
    logic          rst;
    logic [7:0]    host_rx_data;
    logic          host_rx_vld;
    logic          host_rx_rdy;
    logic [7:0]    host_tx_data;
    logic          host_tx_vld;
    logic          host_tx_rdy;
    logic [DW-1:0] mb_rd_data;
    logic          mb_rd_push;
    logic          mb_rd_full;
    logic [DW-1:0] mb_wr_data;
    logic          mb_wr_req;
    logic          tx_done;
    logic          ready;
    logic          rx_err;

    host_link #(
        .DATA_W     (DW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host_rx_data(host_rx_data),
        .host_rx_vld (host_rx_vld),
        .host_rx_rdy (host_rx_rdy),
        .host_tx_data(host_tx_data),
        .host_tx_vld (host_tx_vld),
        .host_tx_rdy (host_tx_rdy),
        .mb_rd_data  (mb_rd_data),
        .mb_rd_push  (mb_rd_push),
        .mb_rd_full  (mb_rd_full),
        .mb_wr_data  (mb_wr_data),
        .mb_wr_req   (mb_wr_req),
        .tx_done     (tx_done),
        .ready       (ready),
        .rx_err      (rx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Observed DUT traffic, pinned against hand-computed literals by the stimulus.
    logic [DW-1:0] dut_rx_log[$];
    logic [7:0]    dut_tx_log[$];
    int            dut_done = 0;

    // Reference model: byte accumulator, pending word, and a word-send phase.
    typedef enum int {M_IDLE, M_SENDING, M_DONE, M_WAIT} m_phase_t;
    bit            armed = 0;
    int            m_n;
    logic [DW-1:0] m_acc;
    logic [DW-1:0] m_word;
    bit            m_pend;
    bit            m_err;
`ifdef HOST_LINK_TIMEOUT_EN
    int            m_idle;
`endif
    m_phase_t      m_tx;
    logic [DW-1:0] m_txw;
    int            m_k;

    always @(negedge clk) begin : compare
        logic exp_rdy, exp_push, exp_txv, exp_done, exp_ready;
        logic [7:0] exp_b;
        exp_rdy   = !m_pend;
        exp_push  = m_pend && !mb_rd_full;
        exp_txv   = (m_tx == M_SENDING);
        exp_done  = (m_tx == M_DONE);
        exp_ready = !m_pend && (m_tx == M_IDLE);
        exp_b     = 8'(m_txw >> (8 * m_k));
        if (armed) begin
            check("host_rx_rdy", 64'(host_rx_rdy), 64'(exp_rdy));
            check("mb_rd_push", 64'(mb_rd_push), 64'(exp_push));
            check("host_tx_vld", 64'(host_tx_vld), 64'(exp_txv));
            check("tx_done", 64'(tx_done), 64'(exp_done));
            check("ready", 64'(ready), 64'(exp_ready));
            check("rx_err", 64'(rx_err), 64'(m_err));
            if (exp_push) check("mb_rd_data", 64'(mb_rd_data), 64'(m_word));
            if (exp_txv) check("host_tx_data", 64'(host_tx_data), 64'(exp_b));
            if (mb_rd_push === 1'b1) dut_rx_log.push_back(mb_rd_data);
            if (host_tx_vld === 1'b1 && host_tx_rdy) dut_tx_log.push_back(host_tx_data);
            if (tx_done === 1'b1) dut_done++;
        end
        if (rst) begin
            m_n = 0; m_acc = '0; m_word = '0; m_pend = 0; m_err = 0;
`ifdef HOST_LINK_TIMEOUT_EN
            m_idle = 0;
`endif
            m_tx = M_IDLE; m_txw = '0; m_k = 0;
            armed = 1;
        end else if (armed) begin
            if (m_pend) begin
                if (!mb_rd_full) m_pend = 0;
            end else if (host_rx_vld) begin
                m_acc[8*m_n +: 8] = host_rx_data;
                m_n++;
`ifdef HOST_LINK_TIMEOUT_EN
                m_idle = 0;
`endif
                if (m_n == BPW) begin
                    m_pend = 1; m_word = m_acc; m_n = 0;
                end
            end
`ifdef HOST_LINK_TIMEOUT_EN
            else if (m_n != 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_n = 0; m_idle = 0; m_err = 1;
                end
            end else begin
                m_idle = 0;
            end
`endif
            case (m_tx)
                M_IDLE:    if (mb_wr_req) begin m_txw = mb_wr_data; m_k = 0; m_tx = M_SENDING; end
                M_SENDING: if (host_tx_rdy) begin m_k++; if (m_k == BPW) m_tx = M_DONE; end
                M_DONE:    m_tx = M_WAIT;
                M_WAIT:    if (!mb_wr_req) m_tx = M_IDLE;
                default:   m_tx = M_IDLE;
            endcase
        end
    end

    task automatic send_rx(input logic [7:0] b);
        bit acc;
        acc = 0;
        host_rx_vld  = 1'b1;
        host_rx_data = b;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = host_rx_rdy;
            @(posedge clk);
            #1;
        end
        host_rx_vld  = 1'b0;
        host_rx_data = '0;
        if (!acc) check("rx_accept_bound", 64'(acc), 64'd1);
    endtask

    task automatic wait_done(input bit toggle);
        bit seen;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = tx_done;
            @(posedge clk);
            #1;
            if (toggle) host_tx_rdy = ~host_tx_rdy;
        end
        if (!seen) check("tx_done_bound", 64'(seen), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bt, bd, br;
        rst = 1'b1;
        host_rx_data = '0; host_rx_vld = 1'b0; host_tx_rdy = 1'b0;
        mb_rd_full = 1'b0; mb_wr_data = '0; mb_wr_req = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rx_rdy", 64'(host_rx_rdy), 64'd1);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_tx_vld", 64'(host_tx_vld), 64'd0);
        check("rst_push", 64'(mb_rd_push), 64'd0);
        check("rst_tx_done", 64'(tx_done), 64'd0);
        check("rst_rx_err", 64'(rx_err), 64'd0);
        check("rst_rd_data", 64'(mb_rd_data), 64'd0);
        check("rst_tx_data", 64'(host_tx_data), 64'd0);
        @(posedge clk); #1;

        // Basic word assembly, LSB byte first.
        send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
        idle(4);
        check("t1_push_count", 64'(dut_rx_log.size()), 64'd1);
        check("t1_word", 64'(dut_rx_log[0]), 64'h44332211);

        // Mailbox full: word holds and host is back-pressured.
        mb_rd_full = 1'b1;
        send_rx(8'hA1); send_rx(8'hA2); send_rx(8'hA3); send_rx(8'hA4);
        idle(5);
        @(negedge clk);
        check("t2_rdy_held", 64'(host_rx_rdy), 64'd0);
        check("t2_no_push", 64'(dut_rx_log.size()), 64'd1);
        @(posedge clk); #1;
        mb_rd_full = 1'b0;
        idle(3);
        check("t2_word", 64'(dut_rx_log[1]), 64'hA4A3A2A1);

        // TX with a host that is only ready every other cycle.
        bt = dut_tx_log.size(); bd = dut_done;
        mb_wr_data = 32'hDEADBEEF; mb_wr_req = 1'b1;
        wait_done(1'b1);
        mb_wr_req = 1'b0; host_tx_rdy = 1'b0;
        idle(3);
        check("t3_bytes", 64'(dut_tx_log.size() - bt), 64'd4);
        check("t3_b0", 64'(dut_tx_log[bt]), 64'hEF);
        check("t3_b1", 64'(dut_tx_log[bt+1]), 64'hBE);
        check("t3_b2", 64'(dut_tx_log[bt+2]), 64'hAD);
        check("t3_b3", 64'(dut_tx_log[bt+3]), 64'hDE);
        check("t3_done", 64'(dut_done - bd), 64'd1);

        // Request left high after completion must not resend.
        bt = dut_tx_log.size();
        host_tx_rdy = 1'b1; mb_wr_data = 32'h0BADF00D; mb_wr_req = 1'b1;
        wait_done(1'b0);
        idle(20);
        check("t4_no_resend", 64'(dut_tx_log.size() - bt), 64'd4);
        check("t4_done_count", 64'(dut_done - bd), 64'd2);
        mb_wr_req = 1'b0;
        idle(2);
        bt = dut_tx_log.size(); br = dut_rx_log.size();
        mb_wr_data = 32'h01020304; mb_wr_req = 1'b1;
        fork
            begin send_rx(8'h0A); send_rx(8'h0B); send_rx(8'h0C); send_rx(8'h0D); end
            wait_done(1'b0);
        join
        mb_wr_req = 1'b0;
        idle(3);
        check("t4_new_b0", 64'(dut_tx_log[bt]), 64'h04);
        check("t4_new_b3", 64'(dut_tx_log[bt+3]), 64'h01);
        check("t4_rx_word", 64'(dut_rx_log[br]), 64'h0D0C0B0A);

        // Partial word followed by a long idle gap.
        br = dut_rx_log.size();
        send_rx(8'h55); send_rx(8'h66);
        repeat (16) @(negedge clk);
        check("t5_err_before", 64'(rx_err), 64'd0);
        @(negedge clk);
`ifdef HOST_LINK_TIMEOUT_EN
        check("t5_err_after", 64'(rx_err), 64'd1);
        @(posedge clk); #1;
        send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
        idle(3);
        check("t5_word", 64'(dut_rx_log[br]), 64'h04030201);
`else
        check("t5_err_after", 64'(rx_err), 64'd0);
        @(posedge clk); #1;
        send_rx(8'h77); send_rx(8'h88);
        idle(3);
        check("t5_word", 64'(dut_rx_log[br]), 64'h88776655);
`endif

        // Reset mid-transfer discards partial RX byte and in-flight TX word.
        br = dut_rx_log.size(); bd = dut_done;
        send_rx(8'h99);
        bt = dut_tx_log.size();
        host_tx_rdy = 1'b1; mb_wr_data = 32'hCAFEF00D; mb_wr_req = 1'b1;
        for (int c = 0; c < 100 && dut_tx_log.size() < bt + 2; c++) @(negedge clk);
        check("t6_two_bytes", 64'(dut_tx_log.size() - bt), 64'd2);
        @(posedge clk); #1;
        rst = 1'b1; host_tx_rdy = 1'b0; mb_wr_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_tx_vld_off", 64'(host_tx_vld), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready", 64'(ready), 64'd1);
        check("t6_rx_rdy", 64'(host_rx_rdy), 64'd1);
        check("t6_rx_err", 64'(rx_err), 64'd0);
        check("t6_no_done", 64'(dut_done - bd), 64'd0);
        @(posedge clk); #1;
        send_rx(8'h10); send_rx(8'h20); send_rx(8'h30); send_rx(8'h40);
        idle(3);
        check("t6_push_count", 64'(dut_rx_log.size() - br), 64'd1);
        check("t6_word", 64'(dut_rx_log[br]), 64'h40302010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
